// File: rtl/ecc_ram_scrubber.sv
// -----------------------------------------------------------------------------
// ecc_ram_scrubber
//
// Background scrubber for an ECC-protected block RAM holding 39-bit SECDED
// codewords (32 data bits + 7 check bits). A start pulse in IDLE launches one
// pass over addresses 0..DEPTH-1. Each word is read, decoded, and:
//   - clean          : skipped                         (3 cycles)
//   - single error   : re-encoded and written back     (4 cycles)
//   - double error   : counted, first address logged   (3 cycles)
//
// Codeword layout (shared by ecc_encode / ecc_decode below):
//   bit 0          overall parity over bits 38:1 (even parity over all 39 bits)
//   bits 38:1      Hamming positions 1..38; check bits sit at positions
//                  1,2,4,8,16,32, data bits 0..31 fill the remaining positions
//                  in ascending order.
//
// Compile-time option:
//   ECC_SCRUB_STOP_ON_DED_EN  when defined, the first double error ends the
//                             pass immediately and raises aborted_o. When not
//                             defined, every pass covers all DEPTH words and
//                             aborted_o is tied low.
//
// Ports:
//   clk_i, rst_n_i      clock (rising edge) and asynchronous active-low reset
//   start_i             starts a pass when idle; ignored otherwise
//   busy_o              high from the cycle after start is accepted to done
//   done_o              one-cycle pulse at the end of the pass
//   ram_addr_o          shared read/write address
//   ram_rd_en_o         read strobe; ram_rdata_i is valid one cycle later
//   ram_rdata_i         codeword returned by the RAM
//   ram_wr_en_o         write strobe
//   ram_wdata_o         corrected codeword for write-back
//   sec_count_o         single errors corrected in the current/last pass
//   ded_count_o         double errors detected in the current/last pass
//   ded_seen_o          at least one double error seen in this pass
//   ded_first_addr_o    address of the first double error (valid with seen)
//   aborted_o           pass ended early on a double error
// -----------------------------------------------------------------------------
module ecc_ram_scrubber #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rd_en_o,
  input  logic [38:0]       ram_rdata_i,
  output logic              ram_wr_en_o,
  output logic [38:0]       ram_wdata_o,
  output logic [CNT_W-1:0]  sec_count_o,
  output logic [CNT_W-1:0]  ded_count_o,
  output logic              ded_seen_o,
  output logic [ADDR_W-1:0] ded_first_addr_o,
  output logic              aborted_o
);

  // ---------------------------------------------------------------------------
  // SECDED code
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] data;
    logic        single_error;
    logic        double_error;
  } dec_t;

  // Hamming positions that are powers of two carry check bits.
  function automatic logic is_check_pos(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // XOR of the indices of all set bits among Hamming positions 1..38.
  function automatic logic [5:0] ecc_syndrome(input logic [38:0] cw);
    logic [5:0] syn;
    syn = '0;
    for (int p = 1; p <= 38; p++) begin
      if (cw[6'(p)]) syn ^= 6'(p);
    end
    return syn;
  endfunction

  function automatic logic [38:0] ecc_encode(input logic [31:0] data);
    logic [38:0] cw;
    logic [5:0]  syn;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= 38; p++) begin
      if (!is_check_pos(p)) begin
        cw[6'(p)] = data[5'(j)];
        j++;
      end
    end
    // With all check bits still zero, the syndrome of the data alone is
    // exactly the check pattern that cancels it.
    syn = ecc_syndrome(cw);
    for (int k = 0; k < 6; k++) begin
      cw[6'(1 << k)] = syn[3'(k)];
    end
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  function automatic dec_t ecc_decode(input logic [38:0] cw);
    dec_t        r;
    logic [38:0] fixed;
    logic [5:0]  syn;
    int          j;
    r     = '0;
    syn   = ecc_syndrome(cw);
    fixed = cw;
    if (^cw) begin
      // Odd overall parity: one flipped bit. A zero syndrome means the
      // parity bit itself flipped; a syndrome past position 38 cannot come
      // from a single flip and is treated as uncorrectable.
      if (syn <= 6'd38) begin
        r.single_error = 1'b1;
        for (int p = 1; p <= 38; p++) begin
          if (syn == 6'(p)) fixed[6'(p)] = ~fixed[6'(p)];
        end
      end else begin
        r.double_error = 1'b1;
      end
    end else if (syn != 6'd0) begin
      r.double_error = 1'b1;
    end
    j = 0;
    for (int p = 1; p <= 38; p++) begin
      if (!is_check_pos(p)) begin
        r.data[5'(j)] = fixed[6'(p)];
        j++;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [38:0]       code_q;
  logic [38:0]       wdata_q;
  dec_t              dec;
  logic              last_addr;

  assign dec         = ecc_decode(code_q);
  assign last_addr   = (addr_q == ADDR_W'(DEPTH - 1));
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_READ;
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = S_CHECK;
      S_CHECK: begin
        // double_error is tested first so it wins if both flags are ever set.
        if (dec.double_error) begin
`ifdef ECC_SCRUB_STOP_ON_DED_EN
          state_d = S_DONE;
`else
          state_d = last_addr ? S_DONE : S_READ;
`endif
        end else if (dec.single_error) begin
          state_d = S_WRITE;
        end else begin
          state_d = last_addr ? S_DONE : S_READ;
        end
      end
      S_WRITE: state_d = last_addr ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so each is high exactly for
  // the cycle spent in its state and no output depends combinationally on
  // ram_rdata_i or start_i.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      code_q           <= '0;
      wdata_q          <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      ram_rd_en_o      <= 1'b0;
      ram_wr_en_o      <= 1'b0;
      sec_count_o      <= '0;
      ded_count_o      <= '0;
      ded_seen_o       <= 1'b0;
      ded_first_addr_o <= '0;
    end else begin
      state_q     <= state_d;
      busy_o      <= (state_d == S_READ)  || (state_d == S_WAIT) ||
                     (state_d == S_CHECK) || (state_d == S_WRITE);
      done_o      <= (state_d == S_DONE);
      ram_rd_en_o <= (state_d == S_READ);
      ram_wr_en_o <= (state_d == S_WRITE);

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q           <= '0;
            sec_count_o      <= '0;
            ded_count_o      <= '0;
            ded_seen_o       <= 1'b0;
            ded_first_addr_o <= '0;
          end
        end
        S_WAIT: code_q <= ram_rdata_i;
        S_CHECK: begin
          if (dec.double_error) begin
            if (ded_count_o != '1) ded_count_o <= ded_count_o + CNT_W'(1);
            if (!ded_seen_o) begin
              ded_seen_o       <= 1'b1;
              ded_first_addr_o <= addr_q;
            end
          end else if (dec.single_error) begin
            if (sec_count_o != '1) sec_count_o <= sec_count_o + CNT_W'(1);
            wdata_q <= ecc_encode(dec.data);
          end
        end
        default: ;
      endcase

      // Any return to READ other than from IDLE is an advance to the next word.
      if (state_d == S_READ && state_q != S_IDLE) addr_q <= addr_q + ADDR_W'(1);
    end
  end

`ifdef ECC_SCRUB_STOP_ON_DED_EN
  logic aborted_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      aborted_q <= 1'b0;
    end else if (state_q == S_IDLE && start_i) begin
      aborted_q <= 1'b0;
    end else if (state_q == S_CHECK && dec.double_error) begin
      aborted_q <= 1'b1;
    end
  end

  assign aborted_o = aborted_q;
`else
  assign aborted_o = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_ram_scrubber.sv
// -----------------------------------------------------------------------------
// tb_ecc_ram_scrubber
//
// Scoreboard bench for ecc_ram_scrubber with DEPTH=8. Stimulus pushes the
// expected RAM reads, writes and end-of-pass status into a queue before each
// pass; a monitor on the falling edge pops and compares whenever the DUT
// strobes ram_rd_en, ram_wr_en or done. A small behavioural RAM answers reads
// one cycle after the strobe.
// -----------------------------------------------------------------------------
module tb_ecc_ram_scrubber;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [38:0]       ram_rdata;
  logic              ram_wr_en;
  logic [38:0]       ram_wdata;
  logic [CNT_W-1:0]  sec_count;
  logic [CNT_W-1:0]  ded_count;
  logic              ded_seen;
  logic [ADDR_W-1:0] ded_first_addr;
  logic              aborted;

  always #5 clk = ~clk;

  ecc_ram_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .busy_o          (busy),
    .done_o          (done),
    .ram_addr_o      (ram_addr),
    .ram_rd_en_o     (ram_rd_en),
    .ram_rdata_i     (ram_rdata),
    .ram_wr_en_o     (ram_wr_en),
    .ram_wdata_o     (ram_wdata),
    .sec_count_o     (sec_count),
    .ded_count_o     (ded_count),
    .ded_seen_o      (ded_seen),
    .ded_first_addr_o(ded_first_addr),
    .aborted_o       (aborted)
  );

  // ---------------------------------------------------------------------------
  // Reference encoder: data in non-power-of-two Hamming positions 1..38,
  // check bit 2^b = parity of data positions whose index has bit b set,
  // bit 0 = overall parity.
  // ---------------------------------------------------------------------------
  function automatic logic [38:0] tb_encode(input logic [31:0] d);
    logic [38:0] cw;
    logic        par;
    int          k;
    cw = '0;
    k  = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[6'(p)] = d[5'(k)];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      par = 1'b0;
      for (int p = 1; p < 39; p++) begin
        if ((((p >> b) & 1) != 0) && ((p & (p - 1)) != 0)) par ^= cw[6'(p)];
      end
      cw[6'(1 << b)] = par;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  // ---------------------------------------------------------------------------
  // RAM model with a preload port owned by the same process.
  // ---------------------------------------------------------------------------
  logic [38:0] mem [DEPTH];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [38:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en)    mem[pre_addr] <= pre_data;
    if (ram_wr_en) mem[ram_addr[2:0]] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= mem[ram_addr[2:0]];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {EV_RD, EV_WR, EV_DONE} ev_kind_e;

  typedef struct {
    ev_kind_e    kind;
    int          addr;
    logic [38:0] data;
    int          sec;
    int          ded;
    logic        seen;
    int          first;
    logic        abrt;
    int          lat;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  first_rd_cyc = -1;
  int  done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_rd(input int a);
    ev_t e;
    e = '{kind: EV_RD, addr: a, data: '0, sec: 0, ded: 0, seen: 1'b0, first: 0, abrt: 1'b0, lat: 0};
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input int a, input logic [38:0] d);
    ev_t e;
    e = '{kind: EV_WR, addr: a, data: d, sec: 0, ded: 0, seen: 1'b0, first: 0, abrt: 1'b0, lat: 0};
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int sec, input int ded, input logic seen,
                           input int first, input logic abrt, input int lat);
    ev_t e;
    e = '{kind: EV_DONE, addr: 0, data: '0, sec: sec, ded: ded, seen: seen,
          first: first, abrt: abrt, lat: lat};
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d at addr %0d, expected nothing (t=%0t)",
               k, ram_addr, $time);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 64'(k), 64'(e.kind));
    case (k)
      EV_RD: check("rd_addr", 64'(ram_addr), 64'(e.addr));
      EV_WR: begin
        check("wr_addr", 64'(ram_addr), 64'(e.addr));
        check("wr_data", 64'(ram_wdata), 64'(e.data));
      end
      default: begin
        check("done_sec_count", 64'(sec_count), 64'(e.sec));
        check("done_ded_count", 64'(ded_count), 64'(e.ded));
        check("done_ded_seen", 64'(ded_seen), 64'(e.seen));
        check("done_ded_first_addr", 64'(ded_first_addr), 64'(e.first));
        check("done_aborted", 64'(aborted), 64'(e.abrt));
        check("done_busy_low", 64'(busy), 64'd0);
        // Latency counts both the first READ cycle and the done cycle.
        check("done_latency", 64'(cyc - first_rd_cyc + 1), 64'(e.lat));
      end
    endcase
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        first_rd_cyc = -1;
      end else begin
        if (ram_rd_en || ram_wr_en) check("rd_wr_exclusive", 64'(ram_rd_en & ram_wr_en), 64'd0);
        if (ram_rd_en) begin
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          observe(EV_RD);
        end
        if (ram_wr_en) observe(EV_WR);
        if (done) begin
          observe(EV_DONE);
          first_rd_cyc = -1;
          done_seen++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic load(input int a, input logic [38:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = 3'(a);
    pre_data = d;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic load_clean();
    for (int i = 0; i < DEPTH; i++) load(i, tb_encode(32'(i)));
  endtask

  task automatic push_clean_reads(input int from, input int to);
    for (int i = from; i <= to; i++) push_rd(i);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for the next done pulse, bounded; a timeout is a failed comparison.
  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_seen == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_seen == d0) begin
      n_checks++;
      $display("FAIL done_timeout: got no done_o within %0d cycles, expected a done pulse", n);
      exp_q.delete();
      apply_reset();
    end
  endtask

  task automatic run_pass();
    int d0;
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0);
    repeat (2) @(negedge clk);
    check("leftover_expected", 64'(exp_q.size()), 64'd0);
  endtask

  localparam logic [38:0] FLIP5   = 39'h00_0000_0020;
  localparam logic [38:0] FLIP0_38 = 39'h40_0000_0001;

  // Watchdog: the bench never hangs.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [38:0] good_3;
    int          d0;
    int          n;
    good_3 = tb_encode(32'hDEAD_BEEF);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_rd_en", 64'(ram_rd_en), 64'd0);
    check("rst_wr_en", 64'(ram_wr_en), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    check("rst_sec", 64'(sec_count), 64'd0);
    check("rst_ded", 64'(ded_count), 64'd0);
    check("rst_ded_seen", 64'(ded_seen), 64'd0);
    check("rst_ded_first", 64'(ded_first_addr), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    rst_n = 1'b1;

    // 1. Clean memory: 8 reads, no writes, 25-cycle pass.
    load_clean();
    push_clean_reads(0, 7);
    push_done(0, 0, 1'b0, 0, 1'b0, 25);
    run_pass();

    // 2. Single error at address 3, then a second pass finds it clean.
    load(3, good_3 ^ FLIP5);
    push_clean_reads(0, 3);
    push_wr(3, good_3);
    push_clean_reads(4, 7);
    push_done(1, 0, 1'b0, 0, 1'b0, 26);
    run_pass();
    check("mem3_corrected", 64'(mem[3]), 64'(good_3));
    push_clean_reads(0, 7);
    push_done(0, 0, 1'b0, 0, 1'b0, 25);
    run_pass();

    // 3. Double errors at addresses 2 and 6.
    load_clean();
    load(2, tb_encode(32'd2) ^ FLIP0_38);
    load(6, tb_encode(32'd6) ^ FLIP0_38);
`ifdef ECC_SCRUB_STOP_ON_DED_EN
    push_clean_reads(0, 2);
    push_done(0, 1, 1'b1, 2, 1'b1, 10);
`else
    push_clean_reads(0, 7);
    push_done(0, 2, 1'b1, 2, 1'b0, 25);
`endif
    run_pass();
    check("ded_no_writeback", 64'(mem[2]), 64'(tb_encode(32'd2) ^ FLIP0_38));
    repeat (5) @(negedge clk);
    check("ded_count_holds", 64'(ded_count), 64'(`ifdef ECC_SCRUB_STOP_ON_DED_EN 1 `else 2 `endif));

    // 4. start held high, with an extra pulse mid-pass: exactly one pass.
    load_clean();
    load(3, good_3 ^ FLIP5);
    push_clean_reads(0, 3);
    push_wr(3, good_3);
    push_clean_reads(4, 7);
    push_done(1, 0, 1'b0, 0, 1'b0, 26);
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1;
    repeat (17) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (done_seen == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (done_seen == d0) begin
      n_checks++;
      $display("FAIL held_start_timeout: got no done_o within %0d cycles, expected a done pulse", n);
      exp_q.delete();
      apply_reset();
    end
    repeat (15) @(negedge clk);
    check("held_start_leftover", 64'(exp_q.size()), 64'd0);
    check("held_start_idle", 64'(busy), 64'd0);
    // A fresh start in IDLE runs a new pass; the word was already corrected.
    push_clean_reads(0, 7);
    push_done(0, 0, 1'b0, 0, 1'b0, 25);
    run_pass();

    // 5. Reset during the WRITE cycle of a corrected word.
    load(3, good_3 ^ FLIP5);
    push_clean_reads(0, 3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ram_wr_en && n < 100);
    check("reached_write", 64'(ram_wr_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_addr", 64'(ram_addr), 64'd0);
    check("arst_wr_en", 64'(ram_wr_en), 64'd0);
    check("arst_wdata", 64'(ram_wdata), 64'd0);
    check("arst_sec", 64'(sec_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_no_write", 64'(mem[3]), 64'(good_3 ^ FLIP5));
    check("arst_leftover", 64'(exp_q.size()), 64'd0);
    check("arst_idle", 64'(busy), 64'd0);
    // FSM and address restarted from zero.
    push_clean_reads(0, 3);
    push_wr(3, good_3);
    push_clean_reads(4, 7);
    push_done(1, 0, 1'b0, 0, 1'b0, 26);
    run_pass();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
